// File: rtl/sfx_sequencer_if.sv
// Game-event and sine-ROM address bundle for sfx_sequencer.
// master = game logic / audio path, slave = the sequencer.
interface sfx_sequencer_if;
  logic       sound_en;
  logic       evt_paddle;
  logic       evt_brick;
  logic       evt_miss;
  logic [4:0] rom_addr;
  logic       mute;
  logic       playing;
  logic [1:0] sfx_id;
  logic       done;

  modport master (
    output sound_en, evt_paddle, evt_brick, evt_miss,
    input  rom_addr, mute, playing, sfx_id, done
  );

  modport slave (
    input  sound_en, evt_paddle, evt_brick, evt_miss,
    output rom_addr, mute, playing, sfx_id, done
  );
endinterface

// File: rtl/sfx_sequencer.sv
// Breakout sound-effect sequencer: plays a short note melody per game event, stepping a sine ROM address.
// Optional `SFX_QUEUE_EN adds a one-deep pending slot for events that arrive while a melody plays.
module sfx_sequencer #(
  parameter int unsigned DO_DIV      = 5972,
  parameter int unsigned RE_DIV      = 5320,
  parameter int unsigned MI_DIV      = 4738,
  parameter int unsigned SOL_DIV     = 3986,
  parameter int unsigned NOTE_CYCLES = 5_000_000,
  parameter int unsigned GAP_CYCLES  = 500_000
) (
  input  logic clk,
  input  logic reset,
  sfx_sequencer_if.slave bus
);

`ifdef SFX_QUEUE_EN
  localparam bit QueueEn = 1'b1;
`else
  localparam bit QueueEn = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_e;

  state_e      state_q, state_d;
  logic [1:0]  sfx_q, sfx_d;
  logic [1:0]  note_q, note_d;
  logic [1:0]  pend_q, pend_d;
  logic [15:0] step_q, step_d;
  logic [22:0] dur_q, dur_d;
  logic [4:0]  addr_q, addr_d;
  logic        done_q, done_d;

  logic [1:0]  evt, nxt, start_id;
  logic [1:0]  last_note;
  logic [15:0] div;
  logic        start, note_end;

  // Accepted event id, already priority-resolved (miss > brick > paddle).
  always_comb begin
    evt = '0;
    if (bus.sound_en) begin
      if (bus.evt_miss)        evt = 2'd3;
      else if (bus.evt_brick)  evt = 2'd2;
      else if (bus.evt_paddle) evt = 2'd1;
    end
  end

  always_comb begin
    div = 16'(SOL_DIV);
    unique case ({sfx_q, note_q})
      4'b10_00: div = 16'(MI_DIV);
      4'b11_01: div = 16'(MI_DIV);
      4'b11_10: div = 16'(RE_DIV);
      4'b11_11: div = 16'(DO_DIV);
      default:  div = 16'(SOL_DIV);
    endcase
    unique case (sfx_q)
      2'd2:    last_note = 2'd1;
      2'd3:    last_note = 2'd3;
      default: last_note = 2'd0;
    endcase
  end

  assign note_end = (dur_q == 23'(NOTE_CYCLES - 1));
  assign nxt      = (evt > pend_q) ? evt : pend_q;

  always_comb begin
    state_d  = state_q;
    sfx_d    = sfx_q;
    note_d   = note_q;
    pend_d   = pend_q;
    step_d   = step_q;
    dur_d    = dur_q;
    addr_d   = addr_q;
    done_d   = 1'b0;
    start    = 1'b0;
    start_id = evt;
    unique case (state_q)
      IDLE: start = (evt != '0);
      PLAY: begin
        dur_d = dur_q + 1'b1;
        if (step_q == div - 16'd1) begin
          step_d = '0;
          addr_d = addr_q + 1'b1;
        end else begin
          step_d = step_q + 1'b1;
        end
        // Melody end wins over preemption; an event on this edge starts as if it came in IDLE.
        if (note_end && note_q == last_note) begin
          done_d   = 1'b1;
          pend_d   = '0;
          start_id = nxt;
          start    = (nxt != '0);
          if (nxt == '0) begin
            state_d = IDLE;
            sfx_d   = '0;
            note_d  = '0;
            step_d  = '0;
            dur_d   = '0;
            addr_d  = '0;
          end
        end else if (evt > sfx_q) begin
          start  = 1'b1;
          pend_d = '0;
        end else begin
          if (note_end) begin
            state_d = GAP;
            note_d  = note_q + 1'b1;
            step_d  = '0;
            dur_d   = '0;
            addr_d  = '0;
          end
          if (QueueEn && evt != '0 && evt > pend_q) pend_d = evt;
        end
      end
      GAP: begin
        dur_d = dur_q + 1'b1;
        if (evt > sfx_q) begin
          start  = 1'b1;
          pend_d = '0;
        end else begin
          if (dur_q == 23'(GAP_CYCLES - 1)) begin
            state_d = PLAY;
            step_d  = '0;
            dur_d   = '0;
            addr_d  = '0;
          end
          if (QueueEn && evt != '0 && evt > pend_q) pend_d = evt;
        end
      end
      default: state_d = IDLE;
    endcase
    if (start) begin
      state_d = PLAY;
      sfx_d   = start_id;
      note_d  = '0;
      step_d  = '0;
      dur_d   = '0;
      addr_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sfx_q   <= '0;
      note_q  <= '0;
      pend_q  <= '0;
      step_q  <= '0;
      dur_q   <= '0;
      addr_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sfx_q   <= sfx_d;
      note_q  <= note_d;
      pend_q  <= pend_d;
      step_q  <= step_d;
      dur_q   <= dur_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
    end
  end

  assign bus.rom_addr = addr_q;
  assign bus.mute     = (state_q != PLAY);
  assign bus.playing  = (state_q != IDLE);
  assign bus.sfx_id   = sfx_q;
  assign bus.done     = done_q;

endmodule
